// File: rtl/issue_scheduler_if.sv
// Fetch-pair input, issue-slot output and statistics bundle for issue_scheduler.
// The scheduler takes the slave modport; the fetch/issue side takes master.
interface issue_scheduler_if #(
  parameter int CNT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_pc_a;
  logic [31:0]      in_instr_a;
  logic             in_b_valid;
  logic [31:0]      in_pc_b;
  logic [31:0]      in_instr_b;
  logic             stall_in;
  logic             flush;
  logic             out_valid_a;
  logic [31:0]      out_pc_a;
  logic [31:0]      out_instr_a;
  logic             out_valid_b;
  logic [31:0]      out_pc_b;
  logic [31:0]      out_instr_b;
  logic [CNT_W-1:0] pair_cnt;
  logic [CNT_W-1:0] split_cnt;

  modport master (
    output in_valid, in_pc_a, in_instr_a, in_b_valid, in_pc_b, in_instr_b,
           stall_in, flush,
    input  in_ready, out_valid_a, out_pc_a, out_instr_a,
           out_valid_b, out_pc_b, out_instr_b, pair_cnt, split_cnt
  );

  modport slave (
    input  in_valid, in_pc_a, in_instr_a, in_b_valid, in_pc_b, in_instr_b,
           stall_in, flush,
    output in_ready, out_valid_a, out_pc_a, out_instr_a,
           out_valid_b, out_pc_b, out_instr_b, pair_cnt, split_cnt
  );
endinterface

// File: rtl/issue_scheduler.sv
// Dual-issue scheduler: pairs fetched instructions or splits them on RAW/WAW,
// memory-port or control conflicts, holding the younger one for a cycle.
module issue_scheduler #(
  parameter int CNT_W = 16
) (
  input logic          clk,
  input logic          reset,
  issue_scheduler_if.slave bus
);

  typedef enum logic [0:0] {ST_PAIR, ST_HOLD} state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef struct packed {
    logic wr_rd;
    logic rd_rs1;
    logic rd_rs2;
    logic mem;
    logic ctrl;
  } op_class_t;

  function automatic op_class_t classify(input logic [6:0] op);
    op_class_t c;
    c = '0;
    c.wr_rd  = (op == OP_R) || (op == OP_I) || (op == OP_LOAD) || (op == OP_JAL) ||
               (op == OP_JALR) || (op == OP_LUI) || (op == OP_AUIPC);
    c.rd_rs1 = (op == OP_R) || (op == OP_I) || (op == OP_LOAD) || (op == OP_STORE) ||
               (op == OP_BRANCH) || (op == OP_JALR);
    c.rd_rs2 = (op == OP_R) || (op == OP_STORE) || (op == OP_BRANCH);
    c.mem    = (op == OP_LOAD) || (op == OP_STORE);
    c.ctrl   = (op == OP_BRANCH) || (op == OP_JAL) || (op == OP_JALR);
    return c;
  endfunction

  state_t           state_reg;
  logic             valid_a_reg;
  logic [31:0]      pc_a_reg;
  logic [31:0]      instr_a_reg;
  logic             valid_b_reg;
  logic [31:0]      pc_b_reg;
  logic [31:0]      instr_b_reg;
  logic [31:0]      hold_pc_reg;
  logic [31:0]      hold_instr_reg;
  logic [CNT_W-1:0] pair_cnt_reg;
  logic [CNT_W-1:0] split_cnt_reg;

  op_class_t  cls_a;
  op_class_t  cls_b;
  logic [4:0] rd_a;
  logic [4:0] rd_b;
  logic [4:0] rs1_b;
  logic [4:0] rs2_b;
  logic       raw_hit;
  logic       waw_hit;
  logic       split_next;

  always_comb begin
    cls_a   = classify(bus.in_instr_a[6:0]);
    cls_b   = classify(bus.in_instr_b[6:0]);
    rd_a    = bus.in_instr_a[11:7];
    rd_b    = bus.in_instr_b[11:7];
    rs1_b   = bus.in_instr_b[19:15];
    rs2_b   = bus.in_instr_b[24:20];
    // Writes to x0 are discarded, so they never create a dependency.
    raw_hit = cls_a.wr_rd && (rd_a != 5'd0) &&
              ((cls_b.rd_rs1 && (rs1_b == rd_a)) || (cls_b.rd_rs2 && (rs2_b == rd_a)));
    waw_hit = cls_a.wr_rd && cls_b.wr_rd && (rd_a != 5'd0) && (rd_a == rd_b);
    split_next = bus.in_b_valid &&
                 (raw_hit || waw_hit || (cls_a.mem && cls_b.mem) || cls_a.ctrl);
  end

  assign bus.in_ready = (state_reg == ST_PAIR) && !bus.stall_in && !bus.flush && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= ST_PAIR;
      valid_a_reg    <= 1'b0;
      pc_a_reg       <= '0;
      instr_a_reg    <= '0;
      valid_b_reg    <= 1'b0;
      pc_b_reg       <= '0;
      instr_b_reg    <= '0;
      hold_pc_reg    <= '0;
      hold_instr_reg <= '0;
      pair_cnt_reg   <= '0;
      split_cnt_reg  <= '0;
    end else if (bus.flush) begin
      state_reg   <= ST_PAIR;
      valid_a_reg <= 1'b0;
      valid_b_reg <= 1'b0;
    end else if (!bus.stall_in) begin
      case (state_reg)
        ST_PAIR: begin
          if (bus.in_valid) begin
            valid_a_reg <= 1'b1;
            pc_a_reg    <= bus.in_pc_a;
            instr_a_reg <= bus.in_instr_a;
            if (split_next) begin
              valid_b_reg    <= 1'b0;
              hold_pc_reg    <= bus.in_pc_b;
              hold_instr_reg <= bus.in_instr_b;
              state_reg      <= ST_HOLD;
              if (split_cnt_reg != '1) split_cnt_reg <= split_cnt_reg + CNT_W'(1);
            end else begin
              valid_b_reg <= bus.in_b_valid;
              pc_b_reg    <= bus.in_pc_b;
              instr_b_reg <= bus.in_instr_b;
              if (bus.in_b_valid && (pair_cnt_reg != '1))
                pair_cnt_reg <= pair_cnt_reg + CNT_W'(1);
            end
          end else begin
            valid_a_reg <= 1'b0;
            valid_b_reg <= 1'b0;
          end
        end
        ST_HOLD: begin
          valid_a_reg <= 1'b1;
          pc_a_reg    <= hold_pc_reg;
          instr_a_reg <= hold_instr_reg;
          valid_b_reg <= 1'b0;
          state_reg   <= ST_PAIR;
        end
        default: state_reg <= ST_PAIR;
      endcase
    end
  end

  assign bus.out_valid_a = valid_a_reg;
  assign bus.out_pc_a    = pc_a_reg;
  assign bus.out_instr_a = instr_a_reg;
  assign bus.out_valid_b = valid_b_reg;
  assign bus.out_pc_b    = pc_b_reg;
  assign bus.out_instr_b = instr_b_reg;
  assign bus.pair_cnt    = pair_cnt_reg;
  assign bus.split_cnt   = split_cnt_reg;

endmodule
